// File: rtl/io_input_port_ctrl.sv
// io_input_port_ctrl
//   Receive side of the memory-mapped input I/O.
//   - Synchronises two asynchronous switch buses.
//   - Debounces two active-low mode keys and counts/flags their presses.
//   - Returns any of this on a CPU read strobe, one cycle later.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   in_port0/1     asynchronous switch buses (DATA_W)
//   and_key        and-mode key, active-low, asynchronous
//   add_key        add-mode key, active-low, asynchronous
//   io_addr        byte address, word select = io_addr[4:2]
//   io_rd          one-cycle read strobe
//   io_read_data   registered read word (holds while io_read_valid=0)
//   io_read_valid  one-cycle pulse, one edge after io_rd
//   key_irq        high while either press flag is set
//
// Register map (io_addr[4:2])
//   0 in_port0 synced, 1 in_port1 synced,
//   2 {add_flag, and_flag} read-to-clear,
//   3 {add_cnt, and_cnt}, 4 {add_level, and_level}, 5-7 zero
module io_input_port_ctrl #(
  parameter int DATA_W  = 32,
  parameter int DEB_CYC = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_port0,
  input  logic [DATA_W-1:0] in_port1,
  input  logic              and_key,
  input  logic              add_key,
  input  logic [7:0]        io_addr,
  input  logic              io_rd,
  output logic [DATA_W-1:0] io_read_data,
  output logic              io_read_valid,
  output logic              key_irq
);

  localparam int DC_W = $clog2(DEB_CYC);
  localparam logic [DC_W-1:0] DEB_MAX = DC_W'(DEB_CYC - 1);

  // Key vectors are indexed 0 = and_key, 1 = add_key.
  logic [DATA_W-1:0] p0_s1_q, p0_s2_q, p1_s1_q, p1_s2_q;
  logic [1:0]        key_s1_q, key_s2_q;
  logic [1:0]        lvl_q, lvl_d;
  logic [DC_W-1:0]   dcnt_q [2];
  logic [DC_W-1:0]   dcnt_d [2];
  logic [CNT_W-1:0]  pcnt_q [2];
  logic [CNT_W-1:0]  pcnt_d [2];
  logic [1:0]        press;
  logic [1:0]        flag_q, flag_d;
  logic              irq_q, irq_d;
  logic              clr_rd;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_vld_q, rd_vld_d;

  always_comb begin
    lvl_d  = lvl_q;
    press  = 2'b00;
    dcnt_d = '{default: '0};
    pcnt_d = pcnt_q;
    for (int k = 0; k < 2; k++) begin
      // The counter only runs while the synced level disagrees; agreement
      // (or acceptance) brings it back to zero.
      if (key_s2_q[k] != lvl_q[k]) begin
        if (dcnt_q[k] == DEB_MAX) begin
          lvl_d[k] = key_s2_q[k];
        end else begin
          dcnt_d[k] = dcnt_q[k] + 1'b1;
        end
      end
      press[k]  = lvl_q[k] & ~lvl_d[k];
      pcnt_d[k] = pcnt_q[k] + CNT_W'(press[k]);
    end

    clr_rd = io_rd && (io_addr[4:2] == 3'd2);
    // A press landing on the clearing edge keeps its flag set.
    flag_d = press | (clr_rd ? 2'b00 : flag_q);
    irq_d  = |flag_d;

    case (io_addr[4:2])
      3'd0:    rd_word = p0_s2_q;
      3'd1:    rd_word = p1_s2_q;
      3'd2:    rd_word = DATA_W'(flag_q);
      3'd3:    rd_word = DATA_W'({pcnt_q[1], pcnt_q[0]});
      3'd4:    rd_word = DATA_W'(lvl_q);
      default: rd_word = '0;
    endcase

    rd_data_d = io_rd ? rd_word : rd_data_q;
    rd_vld_d  = io_rd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p0_s1_q   <= '0;
      p0_s2_q   <= '0;
      p1_s1_q   <= '0;
      p1_s2_q   <= '0;
      key_s1_q  <= 2'b11;
      key_s2_q  <= 2'b11;
      lvl_q     <= 2'b11;
      dcnt_q    <= '{default: '0};
      pcnt_q    <= '{default: '0};
      flag_q    <= 2'b00;
      irq_q     <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      p0_s1_q   <= in_port0;
      p0_s2_q   <= p0_s1_q;
      p1_s1_q   <= in_port1;
      p1_s2_q   <= p1_s1_q;
      key_s1_q  <= {add_key, and_key};
      key_s2_q  <= key_s1_q;
      lvl_q     <= lvl_d;
      dcnt_q    <= dcnt_d;
      pcnt_q    <= pcnt_d;
      flag_q    <= flag_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign io_read_data  = rd_data_q;
  assign io_read_valid = rd_vld_q;
  assign key_irq       = irq_q;

endmodule

// File: tb/tb_io_input_port_ctrl.sv
module tb_io_input_port_ctrl;

  localparam int DATA_W  = 32;
  localparam int DEB_CYC = 4;
  localparam int CNT_W   = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_port0, in_port1;
  logic              and_key, add_key;
  logic [7:0]        io_addr;
  logic              io_rd;
  logic [DATA_W-1:0] io_read_data;
  logic              io_read_valid;
  logic              key_irq;

  io_input_port_ctrl #(.DATA_W(DATA_W), .DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_port0(in_port0), .in_port1(in_port1),
    .and_key(and_key), .add_key(add_key), .io_addr(io_addr), .io_rd(io_rd),
    .io_read_data(io_read_data), .io_read_valid(io_read_valid), .key_irq(key_irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Synced value = what the pin showed two edges earlier.
  // A key level is accepted once the synced key has disagreed with it for
  // DEB_CYC consecutive samples; an accepted 1->0 is a press.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] p0_new, p0_old, p1_new, p1_old;
  bit   [1:0]        k_new, k_old;
  bit   [1:0]        m_lvl, m_flag;
  int                m_run [2];
  int                m_cnt [2];
  bit                rst_edge = 0;

  always @(posedge clock) begin
    bit [1:0]          prs;
    logic [DATA_W-1:0] w;
    prs = 2'b00;
    if (reset) begin
      p0_new = '0; p0_old = '0; p1_new = '0; p1_old = '0;
      k_new = 2'b11; k_old = 2'b11;
      m_lvl = 2'b11; m_flag = 2'b00;
      m_run[0] = 0; m_run[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
      rst_edge = 1;
    end else begin
      rst_edge = 0;
      if (io_rd) begin
        case (io_addr[4:2])
          3'd0:    w = p0_old;
          3'd1:    w = p1_old;
          3'd2:    w = DATA_W'(m_flag);
          3'd3:    w = DATA_W'(m_cnt[1] * (1 << CNT_W) + m_cnt[0]);
          3'd4:    w = DATA_W'(m_lvl);
          default: w = '0;
        endcase
        exp_q.push_back(w);
      end
      for (int k = 0; k < 2; k++) begin
        if (k_old[k] != m_lvl[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == DEB_CYC) begin
            m_lvl[k] = k_old[k];
            m_run[k] = 0;
            if (m_lvl[k] == 1'b0) prs[k] = 1'b1;
          end
        end else begin
          m_run[k] = 0;
        end
        m_cnt[k] = (m_cnt[k] + int'(prs[k])) % (1 << CNT_W);
      end
      if (io_rd && io_addr[4:2] == 3'd2) m_flag = 2'b00;
      m_flag = m_flag | prs;
      p0_old = p0_new; p0_new = in_port0;
      p1_old = p1_new; p1_new = in_port1;
      k_old  = k_new;  k_new  = {add_key, and_key};
    end
  end

  // ---------------- monitor ----------------
  logic [DATA_W-1:0] last_data = '0;

  always @(negedge clock) begin
    logic [DATA_W-1:0] e;
    if (rst_edge) begin
      checks++;
      if (io_read_valid !== 1'b0 || io_read_data !== '0 || key_irq !== 1'b0) begin
        errors++;
        $display("FAIL reset_state valid=%0b data=%h irq=%0b required 0/0/0",
                 io_read_valid, io_read_data, key_irq);
      end
      exp_q.delete();
      last_data = '0;
    end else begin
      checks++;
      if (key_irq !== (m_flag != 2'b00)) begin
        errors++;
        $display("FAIL key_irq got=%0b required=%0b", key_irq, (m_flag != 2'b00));
      end
      if (io_read_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid data=%h required no valid", io_read_data);
        end else begin
          e = exp_q.pop_front();
          if (io_read_data !== e) begin
            errors++;
            $display("FAIL read_data got=%h required=%h", io_read_data, e);
          end
        end
        last_data = io_read_data;
      end else begin
        checks++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          errors++;
          $display("FAIL missing_valid got valid=0 required data=%h", e);
        end else if (io_read_data !== last_data) begin
          errors++;
          $display("FAIL hold_data got=%h required=%h", io_read_data, last_data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic rd(input logic [2:0] word);
    io_rd   = 1'b1;
    io_addr = {3'($urandom), word, 2'($urandom)};
    cyc(1);
    io_rd   = 1'b0;
  endtask

  task automatic press_and(input int low, input int high);
    and_key = 1'b0; cyc(low);
    and_key = 1'b1; cyc(high);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int hold [2];
    reset = 1'b1; in_port0 = '0; in_port1 = '0;
    and_key = 1'b1; add_key = 1'b1; io_addr = '0; io_rd = 1'b0;
    cyc(3);
    reset = 1'b0;

    // T1: synced switch buses, back-to-back reads
    in_port0 = 32'h1F; in_port1 = 32'h18;
    cyc(3);
    rd(3'd0); rd(3'd1); cyc(2);

    // T2: glitch one sample short of acceptance
    and_key = 1'b0; cyc(DEB_CYC - 1); and_key = 1'b1;
    cyc(8);
    rd(3'd4); rd(3'd2); cyc(2);

    // T3: real press, read-to-clear, counter
    and_key = 1'b0; cyc(10); and_key = 1'b1; cyc(8);
    rd(3'd2); rd(3'd2); rd(3'd3); rd(3'd4); cyc(2);

    // T4: add press while addr 2 is read every cycle
    add_key = 1'b0;
    for (int i = 0; i < 12; i++) rd(3'd2);
    add_key = 1'b1; cyc(8);
    rd(3'd2); rd(3'd3); cyc(2);

    // T5: 256 presses wrap and_cnt
    rd(3'd3);
    for (int i = 0; i < 256; i++) press_and(DEB_CYC + 2, DEB_CYC + 2);
    rd(3'd3); rd(3'd2); cyc(2);

    // T6: reset during a pending read with and_flag set
    press_and(DEB_CYC + 2, DEB_CYC + 2);
    io_rd = 1'b1; io_addr = 8'h08; reset = 1'b1;
    cyc(1);
    reset = 1'b0; io_rd = 1'b0;
    cyc(1);
    for (int w = 0; w < 8; w++) rd(3'(w));
    cyc(2);

    // Randomised traffic
    hold[0] = 0; hold[1] = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) in_port0 = $urandom;
      if ($urandom_range(0, 7) == 0) in_port1 = $urandom;
      for (int k = 0; k < 2; k++) begin
        if (hold[k] == 0) begin
          if (k == 0) and_key = ~and_key; else add_key = ~add_key;
          hold[k] = $urandom_range(1, 3 * DEB_CYC);
        end else begin
          hold[k]--;
        end
      end
      io_rd   = ($urandom_range(0, 2) == 0);
      io_addr = 8'($urandom);
      cyc(1);
    end
    io_rd = 1'b0;
    and_key = 1'b1; add_key = 1'b1;
    cyc(12);
    for (int w = 0; w < 8; w++) rd(3'(w));
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
